sort_network_pipe: RTL and testbench

//   Parametrised, fully pipelined ascending sorter for N samples of DATA_W bits.

---
 rtl/sort_network_pipe_pkg.sv | 18 +
 rtl/sort_cas_layer.sv | 22 ++
 rtl/sort_network_pipe.sv | 88 ++++++++
 tb/tb_sort_network_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_network_pipe_pkg.sv
// Shared sorter definitions: pipeline depth helper, layer grouping and the window-size limit.
package sort_network_pipe_pkg;

    localparam int SORT_MAX_N = 49;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Index of the last compare-exchange layer that belongs to register group s.
    function automatic int group_last_layer(input int s, input int lpr, input int n);
        int last;
        last = (s + 1) * lpr;
        if (last > n) last = n;
        return last - 1;
    endfunction

endpackage

// File: rtl/sort_cas_layer.sv
// One combinational odd-even transposition layer: pairs (i,i+1) with i%2 == PARITY.
module sort_cas_layer #(
    parameter int N      = 7,
    parameter int DATA_W = 8,
    parameter int PARITY = 0
) (
    input  logic [N*DATA_W-1:0] src,
    output logic [N*DATA_W-1:0] res
);

    always_comb begin
        res = src;
        for (int i = PARITY; i < N - 1; i += 2) begin
            // Strict compare so equal samples stay in place.
            if (src[i*DATA_W +: DATA_W] > src[(i+1)*DATA_W +: DATA_W]) begin
                res[i*DATA_W +: DATA_W]     = src[(i+1)*DATA_W +: DATA_W];
                res[(i+1)*DATA_W +: DATA_W] = src[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/sort_network_pipe.sv
// Fully pipelined ascending sorter (odd-even transposition, N layers, register every
// LAYERS_PER_REG layers). Define SORT_STALL_EN to add the stall_i pipeline freeze.
module sort_network_pipe
    import sort_network_pipe_pkg::*;
#(
    parameter int N              = 7,
    parameter int DATA_W         = 8,
    parameter int LAYERS_PER_REG = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done_i,
    input  logic [N*DATA_W-1:0] data_i,
`ifdef SORT_STALL_EN
    input  logic                stall_i,
`endif
    output logic                done_o,
    output logic [N*DATA_W-1:0] data_o,
    output logic [DATA_W-1:0]   median_o
);

    localparam int NSTAGE = ceil_div(N, LAYERS_PER_REG);
    localparam int W      = N * DATA_W;
    localparam int MED    = (N - 1) / 2;

    logic [W-1:0]        stage_in  [NSTAGE];
    logic [W-1:0]        stage_out [NSTAGE];
    logic [W-1:0]        data_p    [NSTAGE];
    logic [NSTAGE-1:0]   vld_p;
    logic                advance;

`ifdef SORT_STALL_EN
    assign advance = ~stall_i;
`else
    assign advance = 1'b1;
`endif

    for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
        localparam int FIRST = s * LAYERS_PER_REG;
        localparam int NL    = group_last_layer(s, LAYERS_PER_REG, N) - FIRST + 1;

        logic [W-1:0] chain [NL+1];

        if (s == 0) begin : g_head
            assign stage_in[s] = data_i;
        end else begin : g_body
            assign stage_in[s] = data_p[s-1];
        end

        assign chain[0] = stage_in[s];

        for (genvar j = 0; j < NL; j++) begin : g_layer
            sort_cas_layer #(
                .N      (N),
                .DATA_W (DATA_W),
                .PARITY ((FIRST + j) % 2)
            ) u_layer (
                .src (chain[j]),
                .res (chain[j+1])
            );
        end

        assign stage_out[s] = chain[NL];
    end

    // Stage registers: data loads every advancing cycle, valid travels alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTAGE; s++) begin
                data_p[s] <= '0;
            end
            vld_p <= '0;
        end else if (advance) begin
            vld_p[0] <= done_i;
            for (int s = 1; s < NSTAGE; s++) begin
                vld_p[s] <= vld_p[s-1];
            end
            for (int s = 0; s < NSTAGE; s++) begin
                data_p[s] <= stage_out[s];
            end
        end
    end

    assign done_o   = vld_p[NSTAGE-1];
    assign data_o   = data_p[NSTAGE-1];
    assign median_o = data_p[NSTAGE-1][MED*DATA_W +: DATA_W];

endmodule

// File: tb/tb_sort_network_pipe.sv
// Bench for sort_network_pipe: default N=7 instance plus an N=8, LAYERS_PER_REG=3 instance.
module tb_sort_network_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_i, done_o;
    logic [55:0] data_i, data_o;
    logic [7:0]  median_o;
    logic        done2_i, done2_o;
    logic [63:0] data2_i, data2_o;
    logic [7:0]  median2_o;
`ifdef SORT_STALL_EN
    logic        stall;
`endif

    always #5 clk = ~clk;

    sort_network_pipe #(.N(7), .DATA_W(8), .LAYERS_PER_REG(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .done_i   (done_i),
        .data_i   (data_i),
`ifdef SORT_STALL_EN
        .stall_i  (stall),
`endif
        .done_o   (done_o),
        .data_o   (data_o),
        .median_o (median_o)
    );

    sort_network_pipe #(.N(8), .DATA_W(8), .LAYERS_PER_REG(3)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .done_i   (done2_i),
        .data_i   (data2_i),
`ifdef SORT_STALL_EN
        .stall_i  (1'b0),
`endif
        .done_o   (done2_o),
        .data_o   (data2_o),
        .median_o (median2_o)
    );

    typedef struct {
        logic [55:0] din;
        logic [55:0] dout;
        logic [7:0]  med;
    } vec_t;

    typedef struct {
        int          due;
        logic [63:0] d;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    vec_t tbl [5];
    exp_t q1 [$];
    exp_t q2 [$];

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic logic [55:0] pack7(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6);
        int a [7];
        logic [55:0] p;
        a = '{a0, a1, a2, a3, a4, a5, a6};
        p = '0;
        for (int k = 0; k < 7; k++) p[k*8 +: 8] = a[k][7:0];
        return p;
    endfunction

    function automatic logic [63:0] pack8(input int a0, input int a1, input int a2,
                                          input int a3, input int a4, input int a5,
                                          input int a6, input int a7);
        int a [8];
        logic [63:0] p;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        p = '0;
        for (int k = 0; k < 8; k++) p[k*8 +: 8] = a[k][7:0];
        return p;
    endfunction

    // Reference: gather lanes into a queue and use the built-in sort.
    function automatic logic [63:0] ref_sort(input logic [63:0] v, input int n);
        int q [$];
        int e;
        logic [63:0] r;
        for (int k = 0; k < n; k++) q.push_back(int'(v[k*8 +: 8]));
        q.sort();
        r = '0;
        for (int k = 0; k < n; k++) begin
            e = q[k];
            r[k*8 +: 8] = e[7:0];
        end
        return r;
    endfunction

    task automatic sb_check(input string tag, input logic got_v, input logic [63:0] got_d,
                            input logic [7:0] got_m, input int n, input bit have,
                            input exp_t front, output bit pop);
        bit exp_v;
        exp_v = have && (front.due == cyc);
        chk({tag, "_done"}, 64'(got_v), 64'(exp_v));
        if (exp_v) begin
            chk({tag, "_data"}, got_d, front.d);
            chk({tag, "_median"}, 64'(got_m), 64'(front.d[((n-1)/2)*8 +: 8]));
        end
        pop = exp_v;
    endtask

    initial begin
        int          t;
        int          sets;
        bit          pop;
        exp_t        e;
        exp_t        blank;
        logic [63:0] r;

        blank.due = -1;
        blank.d   = '0;

        tbl[0] = '{pack7(7, 3, 9, 1, 5, 2, 8),           pack7(1, 2, 3, 5, 7, 8, 9),           8'd5};
        tbl[1] = '{pack7(255, 254, 253, 252, 251, 250, 249), pack7(249, 250, 251, 252, 253, 254, 255), 8'd252};
        tbl[2] = '{pack7(42, 42, 42, 42, 42, 42, 42),    pack7(42, 42, 42, 42, 42, 42, 42),    8'd42};
        tbl[3] = '{pack7(0, 0, 0, 0, 0, 0, 1),           pack7(0, 0, 0, 0, 0, 0, 1),           8'd0};
        tbl[4] = '{pack7(200, 10, 200, 10, 200, 10, 200), pack7(10, 10, 10, 200, 200, 200, 200), 8'd200};

        rst = 1'b1; done_i = 1'b0; data_i = '0; done2_i = 1'b0; data2_i = '0;
`ifdef SORT_STALL_EN
        stall = 1'b0;
`endif
        step();
        step();
        chk("rst_done",    64'(done_o),    64'd0);
        chk("rst_data",    64'(data_o),    64'd0);
        chk("rst_median",  64'(median_o),  64'd0);
        chk("rst_done8",   64'(done2_o),   64'd0);
        chk("rst_data8",   data2_o,        64'd0);
        rst = 1'b0;

        // Table vectors issued back-to-back, results expected on consecutive cycles.
        t = cyc;
        for (int i = 0; i < 5; i++) begin
            done_i = 1'b1;
            data_i = tbl[i].din;
            step();
        end
        done_i = 1'b0;
        while (cyc < t + 6) step();
        chk("tbl_early_done", 64'(done_o), 64'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("tbl%0d_done", i),   64'(done_o),   64'd1);
            chk($sformatf("tbl%0d_data", i),   64'(data_o),   64'(tbl[i].dout));
            chk($sformatf("tbl%0d_median", i), 64'(median_o), 64'(tbl[i].med));
            step();
        end
        chk("tbl_after_done", 64'(done_o), 64'd0);

        // Reset while three sets are in flight; done_i during reset must be ignored.
        for (int i = 0; i < 3; i++) begin
            done_i = 1'b1;
            data_i = tbl[i+1].din;
            step();
        end
        rst = 1'b1;
        done_i = 1'b1;
        data_i = tbl[4].din;
        step();
        chk("midrst_done",   64'(done_o),   64'd0);
        chk("midrst_data",   64'(data_o),   64'd0);
        chk("midrst_median", 64'(median_o), 64'd0);
        rst = 1'b0;
        done_i = 1'b1;
        data_i = tbl[0].din;
        t = cyc;
        step();
        done_i = 1'b0;
        while (cyc < t + 7) begin
            chk("midrst_flushed", 64'(done_o), 64'd0);
            step();
        end
        chk("postrst_done",   64'(done_o),   64'd1);
        chk("postrst_data",   64'(data_o),   64'(tbl[0].dout));
        chk("postrst_median", 64'(median_o), 64'd5);
        step();
        chk("postrst_single", 64'(done_o), 64'd0);

        // Grouped layers: N=8, three layers per register, latency 3.
        done2_i = 1'b1;
        data2_i = pack8(0, 255, 1, 254, 2, 253, 3, 252);
        t = cyc;
        step();
        done2_i = 1'b0;
        while (cyc < t + 3) begin
            chk("n8_early_done", 64'(done2_o), 64'd0);
            step();
        end
        chk("n8_done",   64'(done2_o),   64'd1);
        chk("n8_data",   data2_o,        pack8(0, 1, 2, 3, 252, 253, 254, 255));
        chk("n8_median", 64'(median2_o), 64'd3);
        step();
        chk("n8_single", 64'(done2_o), 64'd0);

`ifdef SORT_STALL_EN
        // Stall for four clocks starting at cycle 3 pushes the result to cycle 11.
        done_i = 1'b1;
        data_i = tbl[0].din;
        t = cyc;
        step();
        done_i = 1'b0;
        while (cyc < t + 3) step();
        stall  = 1'b1;
        done_i = 1'b1;
        data_i = tbl[1].din;
        repeat (4) begin
            step();
            chk("stall_held_done", 64'(done_o), 64'd0);
        end
        stall  = 1'b0;
        done_i = 1'b0;
        while (cyc < t + 11) begin
            chk("stall_early_done", 64'(done_o), 64'd0);
            step();
        end
        chk("stall_done",   64'(done_o),   64'd1);
        chk("stall_data",   64'(data_o),   64'(tbl[0].dout));
        chk("stall_median", 64'(median_o), 64'd5);
        repeat (8) begin
            step();
            chk("stall_dropped", 64'(done_o), 64'd0);
        end
`endif

        // Random regression against the queue-sort model, gapped done_i on both instances.
        while (cyc < t + 20) step();
        sets = 0;
        while (sets < 10000) begin
            done_i  = ($urandom_range(0, 2) != 0);
            r       = {$urandom(), $urandom()};
            data_i  = r[55:0];
            if (done_i) begin
                e.due = cyc + 7;
                e.d   = ref_sort(64'(data_i), 7);
                q1.push_back(e);
                sets++;
            end
            done2_i = ($urandom_range(0, 1) != 0);
            r       = {$urandom(), $urandom()};
            data2_i = r;
            if ((r[3:0] == 4'd0) && done2_i) data2_i = {8{r[15:8]}};
            if (done2_i) begin
                e.due = cyc + 3;
                e.d   = ref_sort(data2_i, 8);
                q2.push_back(e);
            end
            step();
            sb_check("rnd7", done_o, 64'(data_o), median_o, 7, q1.size() > 0,
                     (q1.size() > 0) ? q1[0] : blank, pop);
            if (pop) void'(q1.pop_front());
            sb_check("rnd8", done2_o, data2_o, median2_o, 8, q2.size() > 0,
                     (q2.size() > 0) ? q2[0] : blank, pop);
            if (pop) void'(q2.pop_front());
        end
        done_i  = 1'b0;
        done2_i = 1'b0;
        repeat (10) begin
            step();
            sb_check("drain7", done_o, 64'(data_o), median_o, 7, q1.size() > 0,
                     (q1.size() > 0) ? q1[0] : blank, pop);
            if (pop) void'(q1.pop_front());
            sb_check("drain8", done2_o, data2_o, median2_o, 8, q2.size() > 0,
                     (q2.size() > 0) ? q2[0] : blank, pop);
            if (pop) void'(q2.pop_front());
        end
        chk("rnd7_pending", 64'(q1.size()), 64'd0);
        chk("rnd8_pending", 64'(q2.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
